background_palette_fader: RTL and testbench

- Runtime-programmable background colour palette with a frame-synchronised brightness fade engine.
- Sits between the background index source and the VGA colour mux. Maps an INDEX_W-bit pixel index to three CH_W-bit channels.
- Adds a CPU/FSM write port, a 2-stage registered lookup with valid tracking, and fade-in / fade-out over a programmable number of frames.

---
 rtl/bg_palette_pkg.sv | 41 ++++
 rtl/bg_fade_ctrl.sv | 96 +++++++++
 rtl/background_palette_fader.sv | 109 ++++++++++
 tb/tb_background_palette_fader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bg_palette_pkg.sv
// Shared types and helpers for the background palette and its fade engine.
package bg_palette_pkg;

  // Commands accepted on the fade command strobe.
  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_FADE_OUT = 2'd1,
    CMD_FADE_IN  = 2'd2,
    CMD_ABORT    = 2'd3
  } fade_cmd_e;

  // Fade engine states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2
  } fade_state_e;

  // Hand-picked grey ramp used when the palette is 16 entries of 4-bit channels.
  localparam int DEFAULT_GREY_4X4 [16] = '{15, 2, 8, 13, 5, 11, 0, 7,
                                           9, 3, 14, 12, 2, 6, 10, 1};

  // Brightness level that maps every channel onto itself.
  function automatic int full_level(input int level_w);
    return 1 << level_w;
  endfunction

  // Grey value loaded into palette entry idx at reset.
  function automatic int default_grey(input int idx, input int index_w, input int ch_w);
    int num_entries;
    num_entries = 1 << index_w;
    if (index_w == 4 && ch_w == 4 && idx >= 0 && idx < 16) begin
      return DEFAULT_GREY_4X4[idx];
    end
    if (num_entries < 2) begin
      return 0;
    end
    return (idx * ((1 << ch_w) - 1)) / (num_entries - 1);
  endfunction

endpackage

// File: rtl/bg_fade_ctrl.sv
// Fade engine: state machine, frame counter and brightness level register.
module bg_fade_ctrl
  import bg_palette_pkg::*;
#(
  parameter int LEVEL_W         = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [1:0]       fade_cmd,
  input  logic             fade_cmd_valid,
  output logic             fade_busy,
  output logic [LEVEL_W:0] fade_level
);

  localparam int LVL_W = LEVEL_W + 1;
  localparam logic [LEVEL_W:0] FULL = LVL_W'(full_level(LEVEL_W));
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  fade_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEVEL_W:0] level_q, level_d;
  logic [LEVEL_W:0] level_step;
  logic             busy_q;
  fade_cmd_e        cmd;
  logic             abort, want_out, want_in;

  assign cmd      = fade_cmd_e'(fade_cmd);
  assign abort    = fade_cmd_valid && (cmd == CMD_ABORT);
  assign want_out = fade_cmd_valid && (cmd == CMD_FADE_OUT);
  assign want_in  = fade_cmd_valid && (cmd == CMD_FADE_IN);

  // Level after one step in the direction of the active fade.
  assign level_step = (state_q == ST_FADE_OUT) ? level_q - 1'b1 : level_q + 1'b1;

  // Next-state logic: abort overrides everything, start commands only count in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (want_out && level_q != '0) begin
            state_d = ST_FADE_OUT;
            cnt_d   = '0;
          end else if (want_in && level_q != FULL) begin
            state_d = ST_FADE_IN;
            cnt_d   = '0;
          end
        end
        ST_FADE_OUT, ST_FADE_IN: begin
          if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              level_d = level_step;
              if ((state_q == ST_FADE_OUT && level_step == '0) ||
                  (state_q == ST_FADE_IN && level_step == FULL)) begin
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter, level and busy flag registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= FULL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign fade_busy  = busy_q;
  assign fade_level = level_q;

endmodule

// File: rtl/background_palette_fader.sv
// Programmable background palette with a 2-stage lookup and frame-synchronised fade.
module background_palette_fader
  import bg_palette_pkg::*;
#(
  parameter int INDEX_W         = 4,
  parameter int CH_W            = 4,
  parameter int LEVEL_W         = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic               pix_valid_in,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               pix_valid_out,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_addr,
  input  logic [3*CH_W-1:0]  wr_data,
  input  logic               frame_start,
  input  logic [1:0]         fade_cmd,
  input  logic               fade_cmd_valid,
  output logic               fade_busy,
  output logic [LEVEL_W:0]   fade_level
);

  localparam int NUM_ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W       = 3 * CH_W;
  localparam int PROD_W      = CH_W + LEVEL_W + 1;

  logic [RGB_W-1:0] palette [NUM_ENTRIES];
  logic [RGB_W-1:0] s1_rgb;
  logic             s1_valid;

  // Reset value of one palette entry: the default grey on all three channels.
  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    logic [CH_W-1:0] grey;
    grey = CH_W'(default_grey(idx, INDEX_W, CH_W));
    return {3{grey}};
  endfunction

  // Brightness scaling: (c * level) >> LEVEL_W, exact identity at FULL.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [LEVEL_W:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lvl);
    return CH_W'(prod >> LEVEL_W);
  endfunction

  bg_fade_ctrl #(
    .LEVEL_W         (LEVEL_W),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_fade_ctrl (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .fade_cmd       (fade_cmd),
    .fade_cmd_valid (fade_cmd_valid),
    .fade_busy      (fade_busy),
    .fade_level     (fade_level)
  );

  // Palette storage: reloads the default table on reset, otherwise takes CPU writes.
  always_ff @(posedge clk) begin
    // NOTE: the palette must come back to its defaults on reset, so it is built from
    // resettable flops rather than a RAM macro (RAM contents cannot be reset).
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        palette[i] <= default_entry(i);
      end
    end else if (wr_en) begin
      palette[wr_addr] <= wr_data;
    end
  end

  // Stage 1: palette read; sees pre-write contents on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rgb   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_rgb   <= palette[index];
      s1_valid <= pix_valid_in;
    end
  end

  // Stage 2: brightness scaling with the current fade level, blanked when invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        red   <= scale(s1_rgb[2*CH_W +: CH_W], fade_level);
        green <= scale(s1_rgb[CH_W +: CH_W], fade_level);
        blue  <= scale(s1_rgb[0 +: CH_W], fade_level);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_background_palette_fader.sv
// Self-checking bench: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural reference model.
module tb_background_palette_fader;

  localparam int FULL = 16;
  localparam int FPS  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  index;
  logic        pix_valid_in;
  logic [3:0]  red, green, blue;
  logic        pix_valid_out;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_start;
  logic [1:0]  fade_cmd;
  logic        fade_cmd_valid;
  logic        fade_busy;
  logic [4:0]  fade_level;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  int m_pal [16];
  int m_s1_rgb;
  bit m_s1_v;
  int m_out;
  bit m_out_v;
  int m_lvl;
  int m_mode;   // 0 idle, 1 fading out, 2 fading in
  int m_pulses; // frame pulses seen since the last level change / start

  localparam int DEF_TBL [16] = '{15, 2, 8, 13, 5, 11, 0, 7, 9, 3, 14, 12, 2, 6, 10, 1};

  always #5 clk = ~clk;

  background_palette_fader #(
    .INDEX_W(4), .CH_W(4), .LEVEL_W(4), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .index          (index),
    .pix_valid_in   (pix_valid_in),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .pix_valid_out  (pix_valid_out),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_start    (frame_start),
    .fade_cmd       (fade_cmd),
    .fade_cmd_valid (fade_cmd_valid),
    .fade_busy      (fade_busy),
    .fade_level     (fade_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int sc(input int c, input int lvl);
    return (c * lvl) / FULL;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int r, g, b;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_pal[i] = DEF_TBL[i] * 12'h111;
      m_s1_rgb = 0; m_s1_v = 0; m_out = 0; m_out_v = 0;
      m_lvl = FULL; m_mode = 0; m_pulses = 0;
      return;
    end
    // Output stage uses the level held before this edge.
    r = (m_s1_rgb >> 8) & 15;
    g = (m_s1_rgb >> 4) & 15;
    b = m_s1_rgb & 15;
    m_out   = m_s1_v ? ((sc(r, m_lvl) << 8) | (sc(g, m_lvl) << 4) | sc(b, m_lvl)) : 0;
    m_out_v = m_s1_v;
    // Lookup sees the palette before any write on this edge.
    m_s1_rgb = m_pal[int'(index)];
    m_s1_v   = pix_valid_in;
    if (wr_en) m_pal[int'(wr_addr)] = int'(wr_data);
    // Fade behaviour.
    if (fade_cmd_valid && fade_cmd == 2'd3) begin
      m_mode = 0; m_pulses = 0;
    end else if (m_mode == 0) begin
      if (fade_cmd_valid && fade_cmd == 2'd1 && m_lvl > 0) begin
        m_mode = 1; m_pulses = 0;
      end else if (fade_cmd_valid && fade_cmd == 2'd2 && m_lvl < FULL) begin
        m_mode = 2; m_pulses = 0;
      end
    end else if (frame_start) begin
      m_pulses++;
      if (m_pulses == FPS) begin
        m_pulses = 0;
        m_lvl = (m_mode == 1) ? m_lvl - 1 : m_lvl + 1;
        if (m_lvl == 0 || m_lvl == FULL) m_mode = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("pixel", {pix_valid_out, red, green, blue}, {m_out_v, 12'(m_out)});
    check("fade", {fade_busy, fade_level}, {(m_mode != 0), 5'(m_lvl)});
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cycle();
  endtask

  task automatic command(input logic [1:0] c);
    fade_cmd = c;
    fade_cmd_valid = 1'b1;
    cycle();
    fade_cmd_valid = 1'b0;
    fade_cmd = 2'd0;
  endtask

  initial begin
    reset = 1'b1; index = '0; pix_valid_in = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; frame_start = 1'b0; fade_cmd = '0; fade_cmd_valid = 1'b0;

    // Reset state.
    cycle();
    cycle();
    check("rst_level", fade_level, 5'd16);
    check("rst_busy", fade_busy, 1'b0);
    check("rst_pix", {pix_valid_out, red, green, blue}, 13'h0);
    reset = 1'b0;

    // Basic lookup, latency 2, blanking.
    index = 4'd3; pix_valid_in = 1'b1;
    cycle();
    index = 4'd6;
    cycle();
    check("lookup3", {pix_valid_out, red, green, blue}, 13'h1DDD);
    pix_valid_in = 1'b0;
    cycle();
    check("lookup6", {pix_valid_out, red, green, blue}, 13'h1000);
    cycle();
    check("blank", {pix_valid_out, red, green, blue}, 13'h0000);

    // Read-before-write on the same address.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 12'h123; index = 4'd5; pix_valid_in = 1'b1;
    cycle();
    wr_en = 1'b0;
    cycle();
    check("rbw_old", {red, green, blue}, 12'hBBB);
    cycle();
    check("rbw_new", {red, green, blue}, 12'h123);

    // Full fade-out on entry 0.
    index = 4'd0;
    command(2'd1);
    for (int p = 1; p <= 32; p++) begin
      pulse();
      if (p == 2) begin
        check("fo_lvl15", fade_level, 5'd15);
        check("fo_rgbE", {red, green, blue}, 12'hEEE);
      end
    end
    check("fo_lvl0", fade_level, 5'd0);
    check("fo_idle", fade_busy, 1'b0);
    check("fo_black", {red, green, blue}, 12'h000);

    // Full fade-in with an ignored fade-out request halfway.
    command(2'd2);
    for (int p = 1; p <= 32; p++) begin
      pulse();
      if (p == 2) check("fi_lvl1", fade_level, 5'd1);
      if (p == 16) begin
        check("fi_lvl8", fade_level, 5'd8);
        command(2'd1);
        check("fi_ignore", {fade_busy, fade_level}, 6'h28);
      end
    end
    check("fi_full", {fade_busy, fade_level}, 6'h10);

    // Abort coincident with a stepping frame pulse.
    command(2'd1);
    repeat (12) pulse();
    check("ab_lvl10", fade_level, 5'd10);
    pulse();
    fade_cmd = 2'd3; fade_cmd_valid = 1'b1; frame_start = 1'b1;
    cycle();
    fade_cmd = 2'd0; fade_cmd_valid = 1'b0; frame_start = 1'b0;
    cycle();
    check("ab_hold", {fade_busy, fade_level}, 6'h0A);
    repeat (4) pulse();
    check("ab_still", {fade_busy, fade_level}, 6'h0A);

    // Reset mid-fade restores level and palette.
    command(2'd1);
    repeat (10) pulse();
    check("rf_lvl5", {fade_busy, fade_level}, 6'h25);
    reset = 1'b1;
    cycle();
    check("rf_state", {fade_busy, fade_level}, 6'h10);
    check("rf_pix", {pix_valid_out, red, green, blue}, 13'h0);
    reset = 1'b0; index = 4'd5; pix_valid_in = 1'b1;
    cycle();
    cycle();
    check("rf_pal5", {red, green, blue}, 12'hBBB);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 399) == 0);
      index          = 4'($urandom);
      pix_valid_in   = ($urandom_range(0, 3) != 0);
      wr_en          = ($urandom_range(0, 7) == 0);
      wr_addr        = 4'($urandom);
      wr_data        = 12'($urandom);
      frame_start    = ($urandom_range(0, 2) == 0);
      fade_cmd_valid = ($urandom_range(0, 19) == 0);
      fade_cmd       = 2'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
